// File: rtl/sccpu_dmem_pkg.sv
// Shared constants for the single-cycle CPU data memory: address map, depths,
// STATUS bit layout and the address decoder.
package sccpu_dmem_pkg;

  localparam int DATA_W     = 32;
  localparam int RAM_DEPTH  = 64;
  localparam int RAM_AW     = 6;
  localparam int FIFO_DEPTH = 4;
  localparam int FIFO_AW    = 2;
  localparam int CNT_W      = 3;

  localparam logic [3:0]        RAM_TAG        = 4'h0;
  localparam logic [DATA_W-1:0] FIFO_DATA_ADDR = 32'h8000_0000;
  localparam logic [DATA_W-1:0] STATUS_ADDR    = 32'h8000_0004;
  localparam logic [DATA_W-1:0] CYCLES_ADDR    = 32'h8000_0008;

  localparam int ST_EMPTY   = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_CNT_LSB = 3;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_FIFO,
    SEL_STATUS,
    SEL_CYCLES
  } sel_e;

  // Takes the word address (byte address bits 31:2), so the byte offset can never matter.
  function automatic sel_e decode(input logic [DATA_W-3:0] wa);
    if (wa[DATA_W-3 -: 4] == RAM_TAG)          return SEL_RAM;
    if (wa == FIFO_DATA_ADDR[DATA_W-1:2])      return SEL_FIFO;
    if (wa == STATUS_ADDR[DATA_W-1:2])         return SEL_STATUS;
    if (wa == CYCLES_ADDR[DATA_W-1:2])         return SEL_CYCLES;
    return SEL_NONE;
  endfunction

endpackage

// File: rtl/sccpu_dmem_if.sv
// CPU load/store bus plus the output-FIFO stream, bundled for the data memory.
interface sccpu_dmem_if;
  import sccpu_dmem_pkg::*;

  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              wmem;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output addr, wdata, wmem, out_ready,
    input  rdata, out_data, out_valid
  );

  modport slave (
    input  addr, wdata, wmem, out_ready,
    output rdata, out_data, out_valid
  );

endinterface

// File: rtl/sccpu_outfifo.sv
// 4-entry output FIFO: registered head, no bypass, push accepted when full only
// if a pop happens on the same edge.
module sccpu_outfifo
  import sccpu_dmem_pkg::*;
(
  input  logic              clock,
  input  logic              resetn,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] push_data,
  output logic [DATA_W-1:0] data,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              drop
);

  logic [DATA_W-1:0]  mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign drop    = push & full & ~do_pop;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is data only; validity comes from count, so it needs no reset.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/sccpu_dmem.sv
// Data memory for a single-cycle CPU: 64-word RAM with combinational read,
// an output FIFO port, a STATUS register and a free-running cycle counter.
module sccpu_dmem
  import sccpu_dmem_pkg::*;
(
  input  logic         clock,
  input  logic         resetn,
  sccpu_dmem_if.slave  bus
);

  logic [DATA_W-3:0] wa;
  logic [1:0]        unused_byte_ofs;
  sel_e              sel;
  logic [DATA_W-1:0] ram [RAM_DEPTH];
  logic [DATA_W-1:0] cycles;
  logic              ovf;
  logic [DATA_W-1:0] status;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_drop;
  logic              fifo_push;
  logic              fifo_pop;
  logic              st_wr;
  logic              cyc_wr;

  assign wa              = bus.addr[DATA_W-1:2];
  assign unused_byte_ofs = bus.addr[1:0];
  assign sel             = decode(wa);

  assign fifo_push = bus.wmem & (sel == SEL_FIFO);
  assign st_wr     = bus.wmem & (sel == SEL_STATUS);
  assign cyc_wr    = bus.wmem & (sel == SEL_CYCLES);
  assign fifo_pop  = bus.out_valid & bus.out_ready;

  sccpu_outfifo u_fifo (
    .clock     (clock),
    .resetn    (resetn),
    .push      (fifo_push),
    .pop       (fifo_pop),
    .push_data (bus.wdata),
    .data      (bus.out_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .drop      (fifo_drop)
  );

  assign bus.out_valid = ~fifo_empty;

  always_ff @(posedge clock) begin
    if (bus.wmem && sel == SEL_RAM) ram[wa[RAM_AW-1:0]] <= bus.wdata;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)     cycles <= '0;
    else if (cyc_wr) cycles <= '0;
    else             cycles <= cycles + DATA_W'(1);
  end

  // A STATUS write beats a same-edge overflowing push.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)        ovf <= 1'b0;
    else if (st_wr)     ovf <= 1'b0;
    else if (fifo_drop) ovf <= 1'b1;
  end

  always_comb begin
    status                           = '0;
    status[ST_EMPTY]                 = fifo_empty;
    status[ST_FULL]                  = fifo_full;
    status[ST_OVF]                   = ovf;
    status[ST_CNT_LSB +: CNT_W]      = fifo_count;
  end

  always_comb begin
    bus.rdata = '0;
    case (sel)
      SEL_RAM:    bus.rdata = ram[wa[RAM_AW-1:0]];
      SEL_STATUS: bus.rdata = status;
      SEL_CYCLES: bus.rdata = cycles;
      default:    bus.rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_sccpu_dmem.sv
// Scoreboard bench for sccpu_dmem: stimulus queues expectations, a negedge
// monitor pops and compares them, and tracks the FIFO output stream.
module tb_sccpu_dmem;
  import sccpu_dmem_pkg::*;

  logic clock  = 1'b0;
  logic resetn = 1'b1;

  sccpu_dmem_if bus ();

  sccpu_dmem dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t        chk_q[$];
  int          pend = 0;
  logic [31:0] out_q[$];
  exp_t        cur;
  int          n_chk  = 0;
  int          n_fail = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endfunction

  // Monitor: per-cycle expectations on rdata/out_valid/out_data, and the
  // FIFO stream checked whenever a handshake is about to happen.
  always @(negedge clock) begin
    while (pend > 0) begin
      cur = chk_q.pop_front();
      pend--;
      case (cur.sel)
        0:       check(cur.name, bus.rdata, cur.exp);
        1:       check(cur.name, {31'b0, bus.out_valid}, cur.exp);
        default: check(cur.name, bus.out_data, cur.exp);
      endcase
    end
    if (resetn && bus.out_valid && bus.out_ready) begin
      if (out_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL fifo_out: got 0x%08h, want no entry", bus.out_data);
      end else begin
        check("fifo_out", bus.out_data, out_q.pop_front());
      end
    end
  end

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic w);
    bus.addr  = a;
    bus.wdata = d;
    bus.wmem  = w;
  endtask

  task automatic exp_chk(input string n, input int s, input logic [31:0] e);
    chk_q.push_back('{n, s, e});
    pend++;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    bus.wmem = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    drive(a, d, 1'b1);
    step();
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e, input string n);
    drive(a, 32'h0, 1'b0);
    exp_chk(n, 0, e);
    step();
  endtask

  task automatic push(input logic [31:0] d, input bit accepted);
    drive(FIFO_DATA_ADDR, d, 1'b1);
    if (accepted) out_q.push_back(d);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.addr      = STATUS_ADDR;
    bus.wdata     = '0;
    bus.wmem      = 1'b0;
    bus.out_ready = 1'b0;

    // Power-on reset, checked with no clock edge
    #1 resetn = 1'b0;
    #1;
    check("rst_out_valid", {31'b0, bus.out_valid}, 32'h0);
    check("rst_out_data", bus.out_data, 32'h0);
    check("rst_status", bus.rdata, 32'h1);
    bus.addr = CYCLES_ADDR;
    #1;
    check("rst_cycles", bus.rdata, 32'h0);
    resetn = 1'b1;

    repeat (10) @(posedge clock);
    #1;
    rd(CYCLES_ADDR, 32'd10, "cycles_after_10");

    // RAM
    wr(32'h0000_0010, 32'h1234_5678);
    rd(32'h0000_0010, 32'h1234_5678, "ram_read");
    rd(32'h0000_0110, 32'h1234_5678, "ram_alias");
    rd(32'h0000_0013, 32'h1234_5678, "ram_byte_ofs");
    drive(32'h0000_0010, 32'hCAFE_F00D, 1'b1);
    exp_chk("ram_read_during_write", 0, 32'h1234_5678);
    step();
    rd(32'h0000_0010, 32'hCAFE_F00D, "ram_overwrite");
    wr(32'h4000_0010, 32'h0000_FFFF);
    rd(32'h0000_0010, 32'hCAFE_F00D, "unmapped_write");
    rd(32'h9000_0000, 32'h0, "unmapped_read");
    drive(FIFO_DATA_ADDR, 32'h0, 1'b0);
    exp_chk("fifo_data_read", 0, 32'h0);
    exp_chk("idle_valid", 1, 32'h0);
    step();

    // FIFO ordering and overflow
    drive(FIFO_DATA_ADDR, 32'hA, 1'b1);
    out_q.push_back(32'hA);
    exp_chk("no_bypass_valid", 1, 32'h0);
    step();
    drive(FIFO_DATA_ADDR, 32'hB, 1'b1);
    out_q.push_back(32'hB);
    exp_chk("valid_after_push", 1, 32'h1);
    exp_chk("head_after_push", 2, 32'hA);
    step();
    push(32'hC, 1'b1);
    push(32'hD, 1'b1);
    drive(STATUS_ADDR, 32'h0, 1'b0);
    exp_chk("status_full", 0, 32'h22);
    exp_chk("head_hold", 2, 32'hA);
    step();
    push(32'hE, 1'b0);
    rd(STATUS_ADDR, 32'h26, "status_ovf");
    bus.out_ready = 1'b1;
    drive(STATUS_ADDR, 32'h0, 1'b0);
    repeat (4) step();
    exp_chk("drained_valid", 1, 32'h0);
    rd(STATUS_ADDR, 32'h05, "status_drained_ovf");
    bus.out_ready = 1'b0;
    wr(STATUS_ADDR, 32'h1234);
    rd(STATUS_ADDR, 32'h01, "status_ovf_cleared");

    // Full FIFO with simultaneous push and pop
    push(32'h1, 1'b1);
    push(32'h2, 1'b1);
    push(32'h3, 1'b1);
    push(32'h4, 1'b1);
    bus.out_ready = 1'b1;
    push(32'hF, 1'b1);
    bus.out_ready = 1'b0;
    rd(STATUS_ADDR, 32'h22, "status_full_push_pop");
    bus.out_ready = 1'b1;
    drive(STATUS_ADDR, 32'h0, 1'b0);
    repeat (4) step();
    bus.out_ready = 1'b0;
    rd(STATUS_ADDR, 32'h01, "status_empty_again");

    // CYCLES load and wrap
    wr(CYCLES_ADDR, 32'hFFFF);
    rd(CYCLES_ADDR, 32'd0, "cycles_load");
    rd(CYCLES_ADDR, 32'd1, "cycles_incr");
    drive(CYCLES_ADDR, 32'h0, 1'b0);
    force dut.cycles = 32'hFFFF_FFFF;
    #1 release dut.cycles;
    exp_chk("cycles_preload", 0, 32'hFFFF_FFFF);
    step();
    rd(CYCLES_ADDR, 32'd0, "cycles_wrap");

    // Reset pulse mid-queue, checked before any clock edge
    push(32'h11, 1'b1);
    push(32'h22, 1'b1);
    push(32'h33, 1'b1);
    bus.addr = STATUS_ADDR;
    resetn   = 1'b0;
    out_q.delete();
    #1;
    check("midrst_out_valid", {31'b0, bus.out_valid}, 32'h0);
    check("midrst_out_data", bus.out_data, 32'h0);
    check("midrst_status", bus.rdata, 32'h01);
    bus.addr = CYCLES_ADDR;
    #1;
    check("midrst_cycles", bus.rdata, 32'h0);
    #1 resetn = 1'b1;
    rd(STATUS_ADDR, 32'h01, "post_rst_status");
    push(32'h77, 1'b1);
    bus.out_ready = 1'b1;
    drive(STATUS_ADDR, 32'h0, 1'b0);
    step();
    bus.out_ready = 1'b0;
    rd(STATUS_ADDR, 32'h01, "post_rst_drained");

    step();
    n_chk++;
    if (out_q.size() != 0 || pend != 0) begin
      n_fail++;
      $display("FAIL leftover: got %0d entries / %0d checks pending, want 0 / 0", out_q.size(), pend);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sccpu_dmem.md
SCCPU_DMEM -- requirements
Module: sccpu_dmem

Interface
REQ-001 The module SHALL have a single clock and an asynchronous, active-low reset; ports `clock` and `resetn` are listed first.
REQ-002 `clock`  input  1  rising-edge clock shared with the CPU.
REQ-003 `resetn`  input  1  asynchronous active-low reset.
REQ-004 `addr`  input  32  byte address from the CPU ALU result.
REQ-005 `wdata`  input  32  store data from the CPU.
REQ-006 `wmem`  input  1  store enable; sampled at the rising edge.
REQ-007 `rdata`  output  32  load data to the CPU; combinational from `addr`.
REQ-008 `out_data`  output  32  head entry of the output FIFO.
REQ-009 `out_valid`  output  1  FIFO non-empty.
REQ-010 `out_ready`  input  1  the external consumer accepts the head entry when `out_valid` is high at a rising edge.

Function
REQ-011 Address map (word-aligned; `addr[1:0]` SHALL be ignored everywhere):
- RAM: `addr[31:28]`=0; word index `addr[7:2]`; 64 words; aliasing above bit 7 is permitted.
- FIFO_DATA: 0x8000_0000.
- STATUS: 0x8000_0004.
- CYCLES: 0x8000_0008.
- Any other address is unmapped.
REQ-012 RAM read SHALL be combinational with zero latency, so a single-cycle CPU can use it in the same cycle.
REQ-013 RAM write SHALL occur at the rising edge when `wmem`=1; a read of the same word in that cycle SHALL return the old value.
REQ-014 A write to FIFO_DATA SHALL push `wdata` into a 4-entry FIFO. A read of FIFO_DATA SHALL return 0.
REQ-015 A pop SHALL occur at the edge where `out_valid`=1 and `out_ready`=1.
REQ-016 `out_data` SHALL hold steady while `out_valid`=1 and `out_ready`=0.
REQ-017 A push to an empty FIFO SHALL raise `out_valid` in the next cycle; there is no same-cycle bypass.
REQ-018 A push to a full FIFO (count=4) without a simultaneous pop SHALL be dropped and SHALL set the sticky `ovf` bit.
REQ-019 A push and a pop in the same cycle SHALL both succeed at any occupancy, including full; count is unchanged and `ovf` is unaffected.
REQ-020 The FIFO read and write pointers SHALL wrap modulo 4; count range is 0..4.
REQ-021 STATUS read value SHALL be {26'b0, count[2:0], ovf, full, empty}.
REQ-022 Any write to STATUS SHALL clear `ovf` at that edge, regardless of `wdata`. If an overflowing push and a STATUS clear coincide, the clear wins.
REQ-023 CYCLES SHALL be a free-running 32-bit counter that increments by 1 every edge and wraps 0xFFFF_FFFF -> 0.
REQ-024 A write to CYCLES SHALL load 0 at that edge, regardless of `wdata`; the next edge yields 1.
REQ-025 An unmapped read SHALL return 0. An unmapped write SHALL have no effect.
REQ-026 `wmem`=0 SHALL never alter any state except CYCLES increment and FIFO pop.

Reset
REQ-027 While `resetn`=0, the following SHALL hold asynchronously:
- FIFO count, pointers and `ovf` = 0.
- CYCLES = 0.
- `out_valid` = 0.
- `out_data` = 0.
REQ-028 RAM contents SHALL NOT be reset and are undefined until written.
REQ-029 A reset asserted mid-operation SHALL discard all queued FIFO entries. A push coinciding with reset release SHALL be ignored unless the edge follows the deassertion.

Structure
REQ-030 A shared package SHALL hold:
- the address-map constants (RAM region tag, FIFO_DATA, STATUS, CYCLES);
- RAM depth 64 and FIFO depth 4;
- the STATUS bit positions.
REQ-031 The FIFO SHALL be a sub-module `sccpu_outfifo` with push, pop, data, count and full/empty outputs. Decode, RAM and CYCLES SHALL reside in `sccpu_dmem`.

Verification
REQ-032 RAM write/read: write 0x1234_5678 to 0x0000_0010 (`wmem`=1, one edge), then read 0x0000_0010 -> 0x1234_5678. Read 0x0000_0110 (alias) -> 0x1234_5678.
REQ-033 FIFO ordering: with `out_ready`=0, push 0xA, 0xB, 0xC, 0xD.
- STATUS -> 0x22 (count 4, full).
- Fifth push 0xE -> STATUS 0x26 (`ovf` set).
- Then `out_ready`=1 for 4 cycles -> `out_data` sequence A, B, C, D, then `out_valid`=0.
REQ-034 Full simultaneous push/pop: with FIFO full, push 0xF while `out_ready`=1 -> count stays 4, `ovf` stays 0, and 0xF appears as the last entry.
REQ-035 Overflow clear: with `ovf`=1, write any value to STATUS -> the next STATUS read shows `ovf`=0.
REQ-036 CYCLES: after 10 edges out of reset, read -> 10. Write CYCLES -> the next read is 0, then 1 one edge later. Preload via force to 0xFFFF_FFFF -> wraps to 0.
REQ-037 Reset mid-queue: with 3 entries queued, pulse `resetn` low for a partial cycle -> `out_valid`=0, STATUS=0x01 and CYCLES=0 immediately, with no clock edge required.
